// File: rtl/nx1_mem_pkg.sv
// rtl/nx1_mem_pkg.sv - shared state encoding and memory-controller command constants
package nx1_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WDAT = 3'd1,
    ST_CMD  = 3'd2,
    ST_WDRN = 3'd3,
    ST_RDAT = 3'd4
  } state_t;

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  // Seven bits so a 64-word burst count never wraps.
  localparam int CNT_W = 7;

  localparam logic [29:0] ADDR_ALIGN = 30'h3FFF_FFFC;

endpackage

// File: rtl/nx1_marb.sv
// rtl/nx1_marb.sv - CPU/video arbiter and sequencer for the single memory-controller command port
module nx1_marb
  import nx1_mem_pkg::*;
#(
  parameter int V_BL    = 8,
  parameter bit V_FIRST = 1'b1
) (
  input  logic        mem_clk,
  input  logic        mem_rst_n,
  input  logic        mem_init_done,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_empty,
  input  logic        mem_cmd_full,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_full,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_empty,
  input  logic        c_req,
  input  logic        c_wr,
  input  logic [29:0] c_addr,
  input  logic [3:0]  c_mask,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic [31:0] c_rdata,
  input  logic        v_req,
  input  logic [29:0] v_addr,
  output logic        v_rvalid,
  output logic [31:0] v_rdata,
  output logic        v_ack,
  output logic        busy
);

  localparam logic [5:0]       V_CMD_BL = 6'(V_BL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_BL);

  state_t           state;
  logic             rr;
  logic             sel_video;
  logic             sel_wr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             grant_v;
  logic             rd_pop;

  // rr names the side that wins the next tie: 1 = video, 0 = CPU.
  assign grant_v    = v_req && (!c_req || rr);
  assign mem_cmd_en = (state == ST_CMD) && !mem_cmd_full;
  assign mem_wr_en  = (state == ST_WDAT) && !mem_wr_full;
  assign rd_pop     = (state == ST_RDAT) && !mem_rd_empty;
  assign mem_rd_en  = rd_pop;
  assign busy       = (state != ST_IDLE);
  assign cnt_nxt    = cnt + 1'b1;

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state             <= ST_IDLE;
      rr                <= V_FIRST;
      sel_video         <= 1'b0;
      sel_wr            <= 1'b0;
      cnt               <= '0;
      mem_cmd_instr     <= 3'b000;
      mem_cmd_bl        <= 6'd0;
      mem_cmd_byte_addr <= 30'd0;
      mem_wr_mask       <= 4'd0;
      mem_wr_data       <= 32'd0;
      c_ack             <= 1'b0;
      c_rdata           <= 32'd0;
      v_rvalid          <= 1'b0;
      v_rdata           <= 32'd0;
      v_ack             <= 1'b0;
    end else begin
      c_ack    <= 1'b0;
      v_ack    <= 1'b0;
      v_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_init_done && (c_req || v_req)) begin
            sel_video <= grant_v;
            rr        <= !grant_v;
            if (grant_v) begin
              sel_wr            <= 1'b0;
              mem_cmd_instr     <= INSTR_RD;
              mem_cmd_bl        <= V_CMD_BL;
              mem_cmd_byte_addr <= v_addr & ADDR_ALIGN;
              state             <= ST_CMD;
            end else begin
              sel_wr            <= c_wr;
              mem_cmd_instr     <= c_wr ? INSTR_WR : INSTR_RD;
              mem_cmd_bl        <= 6'd0;
              mem_cmd_byte_addr <= c_addr & ADDR_ALIGN;
              mem_wr_mask       <= c_mask;
              mem_wr_data       <= c_wdata;
              state             <= c_wr ? ST_WDAT : ST_CMD;
            end
          end
        end
        ST_WDAT: begin
          if (!mem_wr_full) state <= ST_CMD;
        end
        ST_CMD: begin
          if (!mem_cmd_full) begin
            cnt   <= '0;
            state <= sel_wr ? ST_WDRN : ST_RDAT;
          end
        end
        ST_WDRN: begin
          // Ack only after the controller has drained the write command.
          if (mem_cmd_empty) begin
            c_ack <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_RDAT: begin
          if (rd_pop) begin
            cnt <= cnt_nxt;
            if (sel_video) begin
              v_rvalid <= 1'b1;
              v_rdata  <= mem_rd_data;
              if (cnt_nxt == V_LAST) begin
                v_ack <= 1'b1;
                state <= ST_IDLE;
              end
            end else begin
              c_rdata <= mem_rd_data;
              c_ack   <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nx1_marb.sv
// tb/tb_nx1_marb.sv - scoreboard bench for nx1_marb with a behavioural memory-controller FIFO model
module tb_nx1_marb;
  import nx1_mem_pkg::*;

  typedef struct packed {logic [2:0] instr; logic [5:0] bl; logic [29:0] addr;} cmd_t;
  typedef struct packed {logic [3:0] mask; logic [31:0] data;} wr_t;
  typedef struct packed {logic rd; logic [31:0] data;} cx_t;
  typedef struct packed {logic last; logic [31:0] data;} vx_t;

  logic        mem_clk, mem_rst_n, mem_init_done;
  logic        mem_cmd_en, mem_cmd_empty, mem_cmd_full;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_wr_en, mem_wr_full;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_wr_data;
  logic        mem_rd_en, mem_rd_empty;
  logic [31:0] mem_rd_data;
  logic        c_req, c_wr, c_ack;
  logic [29:0] c_addr;
  logic [3:0]  c_mask;
  logic [31:0] c_wdata, c_rdata;
  logic        v_req, v_rvalid, v_ack, busy;
  logic [29:0] v_addr;
  logic [31:0] v_rdata;

  nx1_marb #(.V_BL(8), .V_FIRST(1'b1)) dut (
    .mem_clk(mem_clk), .mem_rst_n(mem_rst_n), .mem_init_done(mem_init_done),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_cmd_empty(mem_cmd_empty), .mem_cmd_full(mem_cmd_full),
    .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask), .mem_wr_data(mem_wr_data), .mem_wr_full(mem_wr_full),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_empty(mem_rd_empty),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_mask(c_mask), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .v_req(v_req), .v_addr(v_addr), .v_rvalid(v_rvalid), .v_rdata(v_rdata), .v_ack(v_ack),
    .busy(busy)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int n_checks = 0;
  int n_fail = 0;
  cmd_t exp_cmd[$];
  wr_t  exp_wr[$];
  cx_t  exp_c[$];
  vx_t  exp_v[$];

  logic [31:0] rd_q[$];
  int rd_delay = 2, rd_wait = 0, rd_avail = 1000, cmd_busy = 0;
  bit gap_en = 0, force_cmd_full = 0, force_wr_full = 0;
  int n_pops = 0, n_wr = 0, n_cmd = 0;
  bit cap_rd_en = 0, cap_wr_en = 0, cap_cmd_en = 0;
  cmd_t cap_cmd;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [29:0] a, input int i);
    return 32'h1234_5678 + {a[25:2], 8'h00} + 32'(i);
  endfunction

  // Controller model: FIFO state changes at negedge for the posedge just passed.
  initial begin
    forever begin
      @(negedge mem_clk);
      if (!mem_rst_n) begin
        rd_q.delete();
        cmd_busy = 0;
        rd_wait = 0;
      end else begin
        if (cap_rd_en) begin
          if (rd_q.size() != 0) void'(rd_q.pop_front());
          n_pops++;
          rd_avail--;
        end
        if (cap_wr_en) n_wr++;
        if (cap_cmd_en) begin
          n_cmd++;
          cmd_busy = 3;
          if (cap_cmd.instr == INSTR_RD) begin
            for (int i = 0; i <= int'(cap_cmd.bl); i++) rd_q.push_back(word_of(cap_cmd.addr, i));
            rd_wait = rd_delay;
          end
        end else if (cmd_busy > 0) cmd_busy--;
        if (!(cap_cmd_en && cap_cmd.instr == INSTR_RD) && rd_wait > 0) rd_wait--;
      end
      mem_cmd_empty = (cmd_busy == 0);
      mem_cmd_full  = force_cmd_full;
      mem_wr_full   = force_wr_full;
      mem_rd_empty  = (rd_q.size() == 0) || (rd_wait != 0) || (rd_avail <= 0) ||
                      (gap_en && $urandom_range(0, 2) == 0);
      mem_rd_data   = (rd_q.size() != 0) ? rd_q[0] : 32'h0;
      #1;
      cap_rd_en  = mem_rd_en && mem_rst_n;
      cap_wr_en  = mem_wr_en && mem_rst_n;
      cap_cmd_en = mem_cmd_en && mem_rst_n;
      cap_cmd    = '{mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr};
    end
  end

  // Monitor: pops expectations whenever the DUT presents a push or response.
  initial begin
    cmd_t ec; wr_t ew; cx_t ecx; vx_t ev;
    forever begin
      @(negedge mem_clk);
      #2;
      if (mem_rst_n) begin
        if (mem_cmd_en) begin
          if (exp_cmd.size() == 0) check("cmd_unexpected", 64'(mem_cmd_byte_addr), 64'h0);
          else begin
            ec = exp_cmd.pop_front();
            check("cmd", 64'({mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}), 64'(ec));
          end
          check("cmd_en_while_full", 64'(mem_cmd_full), 64'h0);
        end
        if (mem_wr_en) begin
          if (exp_wr.size() == 0) check("wr_unexpected", 64'(mem_wr_data), 64'h0);
          else begin
            ew = exp_wr.pop_front();
            check("wr", 64'({mem_wr_mask, mem_wr_data}), 64'(ew));
          end
          check("wr_en_while_full", 64'(mem_wr_full), 64'h0);
        end
        if (c_ack) begin
          if (exp_c.size() == 0) check("c_ack_unexpected", 64'(c_rdata), 64'h0);
          else begin
            ecx = exp_c.pop_front();
            if (ecx.rd) check("c_rdata", 64'(c_rdata), 64'(ecx.data));
            else check("c_ack_wr", 64'(c_ack), 64'h1);
          end
        end
        if (v_rvalid) begin
          if (exp_v.size() == 0) check("v_unexpected", 64'(v_rdata), 64'h0);
          else begin
            ev = exp_v.pop_front();
            check("v_word", 64'({v_ack, v_rdata}), 64'(ev));
          end
        end
        if (v_ack && !v_rvalid) check("v_ack_without_rvalid", 64'(v_rvalid), 64'h1);
        if (mem_rd_en && !busy) check("pop_outside_rdat", 64'(mem_rd_en), 64'h0);
      end
    end
  end

  task automatic wait_c_ack(input int lim, output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge mem_clk);
      cyc++;
      if (c_ack) seen = 1;
    end
    if (!seen) check("c_ack_timeout", 64'(seen), 64'h1);
  endtask

  task automatic wait_v_ack(input int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge mem_clk);
      if (v_ack) seen = 1;
    end
    if (!seen) check("v_ack_timeout", 64'(seen), 64'h1);
  endtask

  task automatic do_reset();
    @(negedge mem_clk);
    mem_rst_n = 1'b0;
    c_req = 1'b0;
    v_req = 1'b0;
    exp_cmd.delete(); exp_wr.delete(); exp_c.delete(); exp_v.delete();
    repeat (2) @(negedge mem_clk);
  endtask

  initial begin
    int lat, p0, w0, c0;
    mem_rst_n = 1'b0; mem_init_done = 1'b0;
    c_req = 0; c_wr = 0; c_addr = 0; c_mask = 0; c_wdata = 0; v_req = 0; v_addr = 0;
    mem_cmd_empty = 1; mem_cmd_full = 0; mem_wr_full = 0; mem_rd_empty = 1; mem_rd_data = 0;
    repeat (3) @(negedge mem_clk);
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_cmd_en", 64'(mem_cmd_en), 64'h0);
    check("rst_wr_en", 64'(mem_wr_en), 64'h0);
    check("rst_rd_en", 64'(mem_rd_en), 64'h0);
    check("rst_acks", 64'({c_ack, v_ack, v_rvalid}), 64'h0);
    check("rst_rdata", 64'({c_rdata, v_rdata}), 64'h0);
    check("rst_cmd_fields", 64'({mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}), 64'h0);
    @(negedge mem_clk);
    mem_rst_n = 1'b1;

    // Calibration gate, then CPU write
    c_req = 1; c_wr = 1; c_addr = 30'h0000_8005; c_mask = 4'b1101; c_wdata = 32'hA5A5_A5A5;
    exp_wr.push_back('{4'b1101, 32'hA5A5_A5A5});
    exp_cmd.push_back('{INSTR_WR, 6'd0, 30'h0000_8004});
    exp_c.push_back('{1'b0, 32'h0});
    repeat (20) @(negedge mem_clk);
    check("gate_no_cmd", 64'(n_cmd), 64'h0);
    check("gate_no_wr", 64'(n_wr), 64'h0);
    check("gate_idle", 64'(busy), 64'h0);
    mem_init_done = 1'b1;
    @(negedge mem_clk);
    #2;
    check("grant_within_1", 64'(busy), 64'h1);
    c_addr = 30'h3FFF_FFF0; c_mask = 4'b0000; c_wdata = 32'h0;
    wait_c_ack(40, lat);
    c_req = 0;
    check("wr_latency_ge4", 64'(lat >= 4), 64'h1);

    // CPU read, data arrives after 6 cycles
    @(negedge mem_clk);
    rd_delay = 6; c_wr = 0; c_addr = 30'h0;
    exp_cmd.push_back('{INSTR_RD, 6'd0, 30'h0});
    exp_c.push_back('{1'b1, 32'h1234_5678});
    p0 = n_pops;
    c_req = 1;
    wait_c_ack(60, lat);
    c_req = 0;
    repeat (4) @(negedge mem_clk);
    check("cpu_rd_pops", 64'(n_pops - p0), 64'h1);
    check("c_rdata_held", 64'(c_rdata), 64'h1234_5678);

    // Video burst with random gaps
    gap_en = 1; rd_delay = 2; v_addr = 30'h0018_0000;
    exp_cmd.push_back('{INSTR_RD, 6'd7, 30'h0018_0000});
    for (int i = 0; i < 8; i++) exp_v.push_back('{i == 7, 32'h1834_5678 + 32'(i)});
    p0 = n_pops;
    v_req = 1;
    wait_v_ack(300);
    v_req = 0;
    repeat (4) @(negedge mem_clk);
    check("vid_pops", 64'(n_pops - p0), 64'h8);
    check("c_rdata_across_video", 64'(c_rdata), 64'h1234_5678);
    gap_en = 0;

    // Contention from reset: video first, then strict alternation
    do_reset();
    rd_delay = 2; rd_avail = 1000;
    c_req = 1; v_req = 1; c_wr = 0;
    c_addr = 30'h0000_0100; v_addr = 30'h0020_0000;
    for (int k = 0; k < 50; k++) begin
      logic [29:0] va, ca;
      va = 30'h0020_0000 + 30'(64 * k);
      ca = 30'h0000_0100 + 30'(4 * k);
      exp_cmd.push_back('{INSTR_RD, 6'd7, va});
      for (int i = 0; i < 8; i++) exp_v.push_back('{i == 7, word_of(va, i)});
      exp_cmd.push_back('{INSTR_RD, 6'd0, ca});
      exp_c.push_back('{1'b1, word_of(ca, 0)});
    end
    @(negedge mem_clk);
    mem_rst_n = 1'b1;
    fork
      begin
        int l;
        for (int k = 0; k < 50; k++) begin
          wait_c_ack(100, l);
          if (k < 49) c_addr = 30'h0000_0100 + 30'(4 * (k + 1));
          else c_req = 0;
        end
      end
      begin
        for (int k = 0; k < 50; k++) begin
          wait_v_ack(100);
          if (k < 49) v_addr = 30'h0020_0000 + 30'(64 * (k + 1));
          else v_req = 0;
        end
      end
    join
    c_req = 0; v_req = 0;
    repeat (4) @(negedge mem_clk);
    check("cont_cmd_drained", 64'(exp_cmd.size()), 64'h0);
    check("cont_c_drained", 64'(exp_c.size()), 64'h0);
    check("cont_v_drained", 64'(exp_v.size()), 64'h0);

    // Backpressure with a stray read word parked in the read FIFO
    rd_q.push_back(32'hDEAD_BEEF);
    force_cmd_full = 1; force_wr_full = 1;
    c_wr = 1; c_addr = 30'h0000_0040; c_mask = 4'b0000; c_wdata = 32'h3C3C_3C3C;
    exp_wr.push_back('{4'b0000, 32'h3C3C_3C3C});
    exp_cmd.push_back('{INSTR_WR, 6'd0, 30'h0000_0040});
    exp_c.push_back('{1'b0, 32'h0});
    w0 = n_wr; c0 = n_cmd; p0 = n_pops;
    c_req = 1;
    repeat (10) @(negedge mem_clk);
    check("bp_no_wr", 64'(n_wr - w0), 64'h0);
    check("bp_no_cmd", 64'(n_cmd - c0), 64'h0);
    check("bp_busy_held", 64'(busy), 64'h1);
    force_wr_full = 0;
    repeat (4) @(negedge mem_clk);
    check("bp_one_wr", 64'(n_wr - w0), 64'h1);
    check("bp_cmd_still_held", 64'(n_cmd - c0), 64'h0);
    force_cmd_full = 0;
    wait_c_ack(40, lat);
    c_req = 0;
    check("stray_not_popped", 64'(n_pops - p0), 64'h0);
    check("stray_still_queued", 64'(rd_q.size()), 64'h1);

    // Reset in the middle of a stalled video burst
    @(negedge mem_clk);
    rd_q.delete();
    rd_avail = 3; rd_delay = 1; v_addr = 30'h0030_0000;
    exp_cmd.push_back('{INSTR_RD, 6'd7, 30'h0030_0000});
    for (int i = 0; i < 3; i++) exp_v.push_back('{1'b0, 32'h1E34_5678 + 32'(i)});
    v_req = 1;
    repeat (25) @(negedge mem_clk);
    check("rdat_stalled_busy", 64'(busy), 64'h1);
    check("rdat_partial_words", 64'(exp_v.size()), 64'h0);
    mem_rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_strobes", 64'({mem_cmd_en, mem_wr_en, mem_rd_en, c_ack, v_ack, v_rvalid}), 64'h0);
    check("arst_rdata", 64'({c_rdata, v_rdata}), 64'h0);
    check("arst_cmd_fields", 64'({mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}), 64'h0);
    check("arst_wr_fields", 64'({mem_wr_mask, mem_wr_data}), 64'h0);
    v_req = 0;
    rd_avail = 1000;
    repeat (2) @(negedge mem_clk);
    mem_rst_n = 1'b1;
    repeat (3) @(negedge mem_clk);
    check("final_idle", 64'(busy), 64'h0);
    check("final_q_empty", 64'(exp_cmd.size() + exp_wr.size() + exp_c.size() + exp_v.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
